// File: rtl/pipe_nav_fsm.sv
// pipe_nav_fsm: right-hand wall-following navigation controller for the pipe
// robot. Senses on an arrival strobe, services maintenance requests for a fixed
// dwell, picks a turn, then drives for a fixed number of cycles while stepping
// its grid location (saturating at the edges) until a step limit is reached.
module pipe_nav_fsm #(
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned GRID_ROWS = 16,
  parameter int unsigned GRID_COLS = 16,
  parameter int unsigned SVC_CYC   = 4,
  parameter int unsigned MOVE_CYC  = 2,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           onoff,
  input  logic [2*COORD_W-1:0] strt_lcn,
  input  logic                 sns_vld,
  input  logic [3:0]           mtn_sensor,
  input  logic [3:0]           cmps,
  input  logic [2:0]           wll,
  output logic [1:0]           turn,
  output logic [3:0]           facing_dir,
  output logic                 driving,
  output logic [2*COORD_W-1:0] location,
  output logic [2:0]           action,
  output logic [2:0]           c_state,
  output logic [STEP_W-1:0]    step_cnt,
  output logic                 done
);

  localparam int unsigned CNT_MAX = (SVC_CYC > MOVE_CYC) ? SVC_CYC : MOVE_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SENSE   = 3'd1,
    S_SERVICE = 3'd2,
    S_DECIDE  = 3'd3,
    S_MOVE    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] DIR_N = 4'b1000;
  localparam logic [3:0] DIR_E = 4'b0100;
  localparam logic [3:0] DIR_S = 4'b0010;
  localparam logic [3:0] DIR_W = 4'b0001;

  state_t               r_state,   w_state;
  logic [1:0]           r_turn,    w_turn;
  logic [3:0]           r_facing,  w_facing;
  logic                 r_driving, w_driving;
  logic [2*COORD_W-1:0] r_loc,     w_loc;
  logic [2:0]           r_action,  w_action;
  logic [STEP_W-1:0]    r_step,    w_step;
  logic                 r_done,    w_done;
  logic [2:0]           r_wll,     w_wll;
  logic [CNT_W-1:0]     r_cnt,     w_cnt;

  logic [COORD_W-1:0]   w_row, w_col, w_row_nxt, w_col_nxt;
  logic [STEP_W-1:0]    w_step_inc;
  logic [2:0]           w_req_action;

  assign w_row      = r_loc[2*COORD_W-1:COORD_W];
  assign w_col      = r_loc[COORD_W-1:0];
  assign w_step_inc = r_step + 1'b1;

  // Highest pending maintenance bit wins; encoded as bit index + 1.
  always_comb begin
    w_req_action = 3'd0;
    if (mtn_sensor[3])      w_req_action = 3'd4;
    else if (mtn_sensor[2]) w_req_action = 3'd3;
    else if (mtn_sensor[1]) w_req_action = 3'd2;
    else if (mtn_sensor[0]) w_req_action = 3'd1;
  end

  // One-cell step in the current heading, clamped to the grid bounds.
  always_comb begin
    w_row_nxt = w_row;
    w_col_nxt = w_col;
    case (r_facing)
      DIR_N: if (w_row != '0) w_row_nxt = w_row - 1'b1;
      DIR_S: if (w_row < COORD_W'(GRID_ROWS - 1)) w_row_nxt = w_row + 1'b1;
      DIR_E: if (w_col < COORD_W'(GRID_COLS - 1)) w_col_nxt = w_col + 1'b1;
      DIR_W: if (w_col != '0) w_col_nxt = w_col - 1'b1;
      default: ;
    endcase
  end

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    w_state   = r_state;
    w_turn    = r_turn;
    w_facing  = r_facing;
    w_driving = r_driving;
    w_loc     = r_loc;
    w_action  = r_action;
    w_step    = r_step;
    w_done    = r_done;
    w_wll     = r_wll;
    w_cnt     = r_cnt;

    if (onoff == 2'b10) begin
      w_state   = S_IDLE;
      w_driving = 1'b0;
      w_action  = '0;
      w_turn    = '0;
      w_done    = 1'b0;
      w_cnt     = '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (onoff == 2'b01) begin
            w_loc    = strt_lcn;
            w_facing = DIR_N;
            w_step   = '0;
            w_done   = 1'b0;
            w_state  = S_SENSE;
          end
        end
        S_SENSE: begin
          if (sns_vld) begin
            w_wll = wll;
            if ($onehot(cmps)) w_facing = cmps;
            w_cnt = '0;
            if (mtn_sensor != '0) begin
              w_action = w_req_action;
              w_state  = S_SERVICE;
            end else begin
              w_state  = S_DECIDE;
            end
          end
        end
        S_SERVICE: begin
          if (r_cnt == CNT_W'(SVC_CYC - 1)) begin
            w_action = '0;
            w_state  = S_DECIDE;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        S_DECIDE: begin
          // wll is {left, front, right}; right-hand rule checks right first.
          if (!r_wll[0]) begin
            w_turn   = 2'b10;
            w_facing = {r_facing[0], r_facing[3:1]};
          end else if (!r_wll[1]) begin
            w_turn   = 2'b00;
          end else if (!r_wll[2]) begin
            w_turn   = 2'b01;
            w_facing = {r_facing[2:0], r_facing[3]};
          end else begin
            w_turn   = 2'b11;
            w_facing = {r_facing[1:0], r_facing[3:2]};
          end
          w_driving = 1'b1;
          w_cnt     = '0;
          w_state   = S_MOVE;
        end
        S_MOVE: begin
          if (r_cnt == CNT_W'(MOVE_CYC - 1)) begin
            w_loc     = {w_row_nxt, w_col_nxt};
            w_step    = w_step_inc;
            w_driving = 1'b0;
            w_turn    = '0;
            if (w_step_inc == STEP_W'(MAX_STEPS)) begin
              w_done  = 1'b1;
              w_state = S_HALT;
            end else begin
              w_state = S_SENSE;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_turn    <= '0;
      r_facing  <= '0;
      r_driving <= 1'b0;
      r_loc     <= '0;
      r_action  <= '0;
      r_step    <= '0;
      r_done    <= 1'b0;
      r_wll     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_turn    <= w_turn;
      r_facing  <= w_facing;
      r_driving <= w_driving;
      r_loc     <= w_loc;
      r_action  <= w_action;
      r_step    <= w_step;
      r_done    <= w_done;
      r_wll     <= w_wll;
      r_cnt     <= w_cnt;
    end
  end

  assign turn       = r_turn;
  assign facing_dir = r_facing;
  assign driving    = r_driving;
  assign location   = r_loc;
  assign action     = r_action;
  assign c_state    = r_state;
  assign step_cnt   = r_step;
  assign done       = r_done;

endmodule

// File: tb/tb_pipe_nav_fsm.sv
// Directed bench for pipe_nav_fsm with a short step limit (MAX_STEPS=3).
module tb_pipe_nav_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] onoff;
  logic [7:0] strt_lcn;
  logic       sns_vld;
  logic [3:0] mtn_sensor;
  logic [3:0] cmps;
  logic [2:0] wll;
  logic [1:0] turn;
  logic [3:0] facing_dir;
  logic       driving;
  logic [7:0] location;
  logic [2:0] action;
  logic [2:0] c_state;
  logic [7:0] step_cnt;
  logic       done;

  pipe_nav_fsm #(
    .COORD_W  (4),
    .GRID_ROWS(16),
    .GRID_COLS(16),
    .SVC_CYC  (4),
    .MOVE_CYC (2),
    .STEP_W   (8),
    .MAX_STEPS(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .onoff     (onoff),
    .strt_lcn  (strt_lcn),
    .sns_vld   (sns_vld),
    .mtn_sensor(mtn_sensor),
    .cmps      (cmps),
    .wll       (wll),
    .turn      (turn),
    .facing_dir(facing_dir),
    .driving   (driving),
    .location  (location),
    .action    (action),
    .c_state   (c_state),
    .step_cnt  (step_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam int unsigned F_TURN = 0, F_FACE = 1, F_DRV = 2, F_LOC = 3,
                          F_ACT  = 4, F_ST   = 5, F_STEP = 6, F_DONE = 7;

  typedef struct {
    string       tag;
    int unsigned fld;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [15:0] observe(int unsigned f);
    case (f)
      F_TURN:  return 16'(turn);
      F_FACE:  return 16'(facing_dir);
      F_DRV:   return 16'(driving);
      F_LOC:   return 16'(location);
      F_ACT:   return 16'(action);
      F_ST:    return 16'(c_state);
      F_STEP:  return 16'(step_cnt);
      F_DONE:  return 16'(done);
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic ex(input string tag, input int unsigned fld, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.fld);
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; onoff = 2'b00; strt_lcn = 8'h00; sns_vld = 1'b0;
    mtn_sensor = 4'h0; cmps = 4'h0; wll = 3'b000;

    // Reset state
    ex("rst_state", F_ST, 0); ex("rst_loc", F_LOC, 0); ex("rst_face", F_FACE, 0);
    ex("rst_drv", F_DRV, 0); ex("rst_step", F_STEP, 0); ex("rst_done", F_DONE, 0);
    ex("rst_act", F_ACT, 0); ex("rst_turn", F_TURN, 0);
    cyc();
    rst = 1'b0;

    // Start at 0x60
    onoff = 2'b01; strt_lcn = 8'h60;
    ex("start_state", F_ST, 1); ex("start_loc", F_LOC, 8'h60);
    ex("start_face", F_FACE, 4'b1000); ex("start_step", F_STEP, 0);
    cyc();
    onoff = 2'b00;

    // Move 1: right open, facing N -> E, col+1
    sns_vld = 1'b1; cmps = 4'b1000; wll = 3'b110; mtn_sensor = 4'h0;
    ex("m1_decide", F_ST, 3);
    cyc();
    sns_vld = 1'b0;
    ex("m1_state", F_ST, 4); ex("m1_turn", F_TURN, 2'b10);
    ex("m1_face", F_FACE, 4'b0100); ex("m1_drv_c1", F_DRV, 1);
    cyc();
    ex("m1_drv_c2", F_DRV, 1); ex("m1_turn_hold", F_TURN, 2'b10); ex("m1_state_c2", F_ST, 4);
    cyc();
    ex("m1_sense", F_ST, 1); ex("m1_drv_off", F_DRV, 0); ex("m1_loc", F_LOC, 8'h61);
    ex("m1_step", F_STEP, 1); ex("m1_turn_clr", F_TURN, 0);
    cyc();

    // Move 2: service 0101 -> action 3 for 4 cycles, then left turn E -> N
    sns_vld = 1'b1; cmps = 4'b0100; wll = 3'b011; mtn_sensor = 4'b0101;
    ex("svc_state", F_ST, 2); ex("svc_act_c1", F_ACT, 3); ex("svc_drv", F_DRV, 0);
    cyc();
    sns_vld = 1'b0; mtn_sensor = 4'h0;
    for (int i = 0; i < 3; i++) begin
      ex("svc_state_hold", F_ST, 2); ex("svc_act_hold", F_ACT, 3); ex("svc_drv_hold", F_DRV, 0);
      cyc();
    end
    ex("svc_exit_state", F_ST, 3); ex("svc_exit_act", F_ACT, 0);
    cyc();
    ex("m2_state", F_ST, 4); ex("m2_turn", F_TURN, 2'b01);
    ex("m2_face", F_FACE, 4'b1000); ex("m2_drv", F_DRV, 1);
    cyc();
    ex("m2_drv_c2", F_DRV, 1);
    cyc();
    ex("m2_sense", F_ST, 1); ex("m2_loc", F_LOC, 8'h51); ex("m2_step", F_STEP, 2);
    ex("m2_turn_clr", F_TURN, 0); ex("m2_act", F_ACT, 0);
    cyc();

    // Move 3: dead end facing E -> U-turn to W, col-1, step limit reached
    sns_vld = 1'b1; cmps = 4'b0100; wll = 3'b111;
    ex("m3_decide", F_ST, 3); ex("m3_face_cmps", F_FACE, 4'b0100);
    cyc();
    sns_vld = 1'b0;
    ex("m3_turn", F_TURN, 2'b11); ex("m3_face", F_FACE, 4'b0001);
    cyc();
    ex("m3_drv_c2", F_DRV, 1);
    cyc();
    ex("halt_state", F_ST, 5); ex("halt_done", F_DONE, 1); ex("halt_loc", F_LOC, 8'h50);
    ex("halt_step", F_STEP, 3); ex("halt_drv", F_DRV, 0); ex("halt_turn", F_TURN, 0);
    cyc();

    // sns_vld in HALT has no effect
    sns_vld = 1'b1; cmps = 4'b1000; wll = 3'b000;
    ex("halt_ign_state", F_ST, 5); ex("halt_ign_face", F_FACE, 4'b0001);
    cyc();
    sns_vld = 1'b0;

    // Restart from HALT at 0x00
    onoff = 2'b01; strt_lcn = 8'h00;
    ex("rs_state", F_ST, 1); ex("rs_loc", F_LOC, 8'h00); ex("rs_step", F_STEP, 0);
    ex("rs_done", F_DONE, 0); ex("rs_face", F_FACE, 4'b1000);
    cyc();
    onoff = 2'b00;

    // Front open at row 0 facing N: location saturates, step still counts
    sns_vld = 1'b1; cmps = 4'b1000; wll = 3'b101;
    ex("sat_decide", F_ST, 3);
    cyc();
    sns_vld = 1'b0;
    ex("sat_state", F_ST, 4); ex("sat_turn", F_TURN, 2'b00);
    ex("sat_face", F_FACE, 4'b1000); ex("sat_drv", F_DRV, 1);
    cyc();
    ex("sat_drv_c2", F_DRV, 1);
    cyc();
    ex("sat_sense", F_ST, 1); ex("sat_loc", F_LOC, 8'h00); ex("sat_step", F_STEP, 1);
    cyc();

    // Non-one-hot compass keeps heading N; right turn -> E, col+1
    sns_vld = 1'b1; cmps = 4'b0110; wll = 3'b110;
    ex("badcmps_face", F_FACE, 4'b1000);
    cyc();
    sns_vld = 1'b0;
    ex("badcmps_turn", F_TURN, 2'b10); ex("badcmps_rot", F_FACE, 4'b0100);
    cyc();
    cyc();
    ex("badcmps_loc", F_LOC, 8'h01); ex("badcmps_step", F_STEP, 2);
    cyc();

    // Stop in cycle 2 of SERVICE
    sns_vld = 1'b1; cmps = 4'b0100; wll = 3'b000; mtn_sensor = 4'b1000;
    ex("stop_svc_state", F_ST, 2); ex("stop_svc_act", F_ACT, 4);
    cyc();
    sns_vld = 1'b0; mtn_sensor = 4'h0;
    ex("stop_svc_c2", F_ST, 2);
    cyc();
    onoff = 2'b10;
    ex("stop_state", F_ST, 0); ex("stop_act", F_ACT, 0); ex("stop_loc", F_LOC, 8'h01);
    ex("stop_step", F_STEP, 2); ex("stop_face", F_FACE, 4'b0100); ex("stop_drv", F_DRV, 0);
    cyc();
    onoff = 2'b00;
    ex("idle_hold", F_ST, 0);
    cyc();

    // Restart at 0x37, reset pulse mid-MOVE
    onoff = 2'b01; strt_lcn = 8'h37;
    ex("r2_state", F_ST, 1); ex("r2_loc", F_LOC, 8'h37); ex("r2_step", F_STEP, 0);
    cyc();
    onoff = 2'b00;
    sns_vld = 1'b1; cmps = 4'b0010; wll = 3'b101;
    ex("r2_face", F_FACE, 4'b0010);
    cyc();
    sns_vld = 1'b0;
    ex("r2_move", F_ST, 4); ex("r2_drv", F_DRV, 1);
    cyc();
    #2 rst = 1'b1;
    #1;
    ex("arst_drv", F_DRV, 0); ex("arst_loc", F_LOC, 0); ex("arst_step", F_STEP, 0);
    ex("arst_state", F_ST, 0); ex("arst_face", F_FACE, 0);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Bottom-edge saturation: row 15 facing S stays at row 15
    onoff = 2'b01; strt_lcn = 8'hF5;
    ex("bot_start", F_ST, 1);
    cyc();
    onoff = 2'b00;
    sns_vld = 1'b1; cmps = 4'b0010; wll = 3'b101;
    cyc();
    sns_vld = 1'b0;
    ex("bot_move", F_ST, 4); ex("bot_face", F_FACE, 4'b0010);
    cyc();
    cyc();
    ex("bot_sense", F_ST, 1); ex("bot_loc", F_LOC, 8'hF5); ex("bot_step", F_STEP, 1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_nav_fsm.md
Name: pipe_nav_fsm

Overview:
- Parametrised successor to the pipe-robot controller FSM: one clock, grid-size and timing generics.
- Adds arrival-strobed sensing, multi-cycle service dwell, multi-cycle moves, grid-edge saturation, step counter with halt limit.
- Sits between the sensor front-end (walls, compass, maintenance sensor) and the drive/steer actuators.
- Policy: right-hand wall follow.

Parameters:
- COORD_W, 4: bits per row/column coordinate; location is 2*COORD_W bits.
- GRID_ROWS, 16: rows; valid row is 0..GRID_ROWS-1.
- GRID_COLS, 16: columns; valid column is 0..GRID_COLS-1.
- SVC_CYC, 4: cycles action is held in SERVICE (>=1).
- MOVE_CYC, 2: cycles driving is held in MOVE (>=1).
- STEP_W, 8: step counter width.
- MAX_STEPS, 255: completed moves before HALT (1..2^STEP_W-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- onoff  in  2  01=start, 10=stop, 00/11=no-op.
- strt_lcn  in  2*COORD_W  start location {row,col}.
- sns_vld  in  1  strobe: wll/mtn_sensor/cmps valid for the current cell.
- mtn_sensor  in  4  maintenance request bits.
- cmps  in  4  compass, one-hot: N=1000, E=0100, S=0010, W=0001.
- wll  in  3  walls {left,front,right}; 1=wall.
- turn  out  2  00=straight, 01=left, 10=right, 11=U-turn.
- facing_dir  out  4  current heading, one-hot as cmps.
- driving  out  1  high while moving.
- location  out  2*COORD_W  current {row,col}.
- action  out  3  0=none, 1..4=servicing mtn_sensor bit 0..3.
- c_state  out  3  state code.
- step_cnt  out  STEP_W  completed moves.
- done  out  1  high in HALT.

Behaviour:
- rst high: state IDLE, all outputs 0, immediately (async), including mid-operation.
- State codes: IDLE=0, SENSE=1, SERVICE=2, DECIDE=3, MOVE=4, HALT=5.
- onoff=10 in any state: next state IDLE. Clears driving, action, turn, done. Keeps location, facing_dir, step_cnt. Overrides every other event that cycle.
- IDLE: onoff=01 loads location<=strt_lcn, facing_dir<=1000, step_cnt<=0, then SENSE. onoff=01 in SENSE/SERVICE/DECIDE/MOVE is ignored.
- SENSE: waits for sns_vld.
  - On sns_vld: register wll and mtn_sensor. If cmps is one-hot, facing_dir<=cmps; otherwise keep facing_dir.
  - Registered mtn_sensor!=0: go SERVICE. Else: go DECIDE.
- SERVICE:
  - action = (index of highest set bit)+1, held exactly SVC_CYC cycles, driving=0.
  - Then action<=0 and go DECIDE.
- DECIDE: one cycle, using the registered walls.
  - Right open: turn=10, rotate facing right (N->E->S->W->N).
  - Else front open: turn=00.
  - Else left open: turn=01, rotate facing left.
  - Else: turn=11, rotate 180°.
  - Next state MOVE.
- MOVE:
  - driving=1 for exactly MOVE_CYC cycles; turn holds its value.
  - On the last cycle, update location: N row-1, S row+1, E col+1, W col-1.
  - Saturate at 0 and at GRID_ROWS-1 / GRID_COLS-1; no wrap.
  - step_cnt increments even when the location saturates.
  - Then driving=0 and turn=00. If step_cnt==MAX_STEPS: HALT, else SENSE.
- HALT: done=1, driving=0. onoff=01 behaves as in IDLE (reload start location, step_cnt=0, done=0, go SENSE).
- sns_vld outside SENSE is ignored.
- All outputs are registered.

Test Plan:
- Start at 8'h60, sns_vld with cmps=1000, wll=110, mtn=0000. Required: turn=10, facing=0100, driving high 2 cycles, location=8'h61, step_cnt=1, c_state=1.
- In SENSE with mtn_sensor=0101, wll=011. Required: c_state=2, action=3 for 4 cycles, driving=0. Then action=0, turn=00, location row-1 when facing N.
- Location 8'h00 facing N, wll=101. Required: turn=00, location stays 8'h00, step_cnt increments.
- wll=111 facing E. Required: turn=11, facing=0001.
- Bench with MAX_STEPS=3: after the 3rd move, c_state=5, done=1. onoff=01 then reloads strt_lcn, step_cnt=0, done=0.
- Stop and reset interrupts:
  - onoff=10 in cycle 2 of SERVICE: next cycle c_state=0, action=0, location retained.
  - rst pulse mid-MOVE: driving, location, step_cnt all 0 before the next clk edge.
